fp_div_iter: RTL and testbench
==============================

// Module: fp_div_iter
// PURPOSE
//  Parametrised, iterative IEEE-754 binary floating-point divider (a/b), one quotient bit per clock.
//  Successor to the combinational double divider: generic width, round-to-nearest-even, exception flags, valid/ready streaming.
//  Sits in the FPU datapath beside add/mul units; one operation in flight; result held until consumed.
// PARAMETERS
//  EXP_W   11  exponent field width; BIAS = 2**(EXP_W-1)-1 (local)
//  FRAC_W  52  stored fraction width; W = 1+EXP_W+FRAC_W (local), 64 at defaults
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     operands valid
//  in_ready   out  1     divider idle, accepts operands
//  in_a       in   W     dividend {sign,exp,frac}
//  in_b       in   W     divisor
//  out_valid  out  1     result valid, held until taken
//  out_ready  in   1     consumer accepts result
//  out_data   out  W     quotient
//  out_flags  out  5     {invalid, div_by_zero, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0; any in-flight op discarded, no output.
//  FSM: IDLE -> PREP -> DIV -> ROUND -> DONE -> IDLE.
//   IDLE: in_ready=1; in_valid&in_ready registers in_a/in_b, goes PREP. in_ready=0 in every other state.
//   PREP (1 cyc): unpack, classify, normalise mantissas to 1.f (priority encoder, exponent adjusted),
//     exp_q = ea-eb+BIAS in signed EXP_W+2 bits; if a_mant<b_mant pre-shift dividend left 1, exp_q-1.
//   DIV (FRAC_W+3 cyc): restoring radix-2; quotient bits = 1 int + FRAC_W + guard + round; sticky = remainder!=0.
//   ROUND (1 cyc): RNE on guard/round/sticky; mantissa carry-out -> exp_q+1, mant=1.0.
//     exp_q >= 2**EXP_W-1 -> signed inf, overflow+inexact.
//     exp_q <= 0 -> denormalise (subnormal support), tiny rounding; underflow only if tiny AND inexact.
//   DONE: out_valid=1; out_data/out_flags stable while out_ready=0; on out_valid&out_ready -> IDLE next edge.
//  Latency: out_valid rises FRAC_W+5 edges after accepting edge (57 at defaults), fixed for all operands.
//  Special cases (still fixed latency; priority top-down):
//   NaN input -> canonical qNaN {0,all-ones,1,0...}; invalid only if an input is sNaN.
//   0/0, inf/inf -> qNaN, invalid. x/0 (x finite non-zero) -> signed inf, div_by_zero.
//   0/x, x/inf -> signed zero. inf/x -> signed inf. No flags for these.
//  Sign = sign_a ^ sign_b for all non-NaN results.
//  in_valid during busy states is ignored (not latched); operands are sampled only at the accept edge.
//  No back-to-back accept in the same cycle as output handshake; next accept earliest one cycle later.
// CONFIGURATION
//  FP_DIV_SUBNORM_EN defined: subnormal inputs normalised in PREP; tiny results delivered as subnormals with RNE.
//  FP_DIV_SUBNORM_EN undefined: subnormal inputs treated as signed zero (no flag);
//   any result with exp_q<=0 flushed to signed zero with underflow+inexact. Latency unchanged.
// TESTING (defaults EXP_W=11, FRAC_W=52)
//  4024000000000000 / 4000000000000000 -> 4014000000000000, flags 00000, out_valid exactly 57 edges after accept.
//  3FF0000000000000 / 4008000000000000 -> 3FD5555555555555, flags 00001;
//   C010000000000000 / 4000000000000000 -> C000000000000000.
//  3FF0000000000000 / 0 -> 7FF0000000000000 flags 01000; 0/0 -> 7FF8000000000000 flags 10000;
//   7FF0000000000001 / 3FF0000000000000 -> 7FF8000000000000 flags 10000.
//  7FEFFFFFFFFFFFFF / 3FE0000000000000 -> 7FF0000000000000 flags 00101.
//  0010000000000000 / 4000000000000000 -> EN: 0008000000000000 flags 00000; not EN: 0000000000000000 flags 00011.
//  Hold out_ready=0 10 cycles: out_data/out_flags stable, in_ready=0, new in_valid ignored;
//   assert rst at cycle 20 of next op -> out_valid=0, in_ready=1 next edge, no result emitted.

Source files
------------

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: restoring radix-2, one quotient bit per clock, RNE, exception flags.
// Optional FP_DIV_SUBNORM_EN: gradual underflow (subnormal in/out); undefined flushes subnormals to zero.

module fp_div_iter #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] in_a,
  input  logic [EXP_W+FRAC_W:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] out_data,
  output logic [4:0]            out_flags
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = FRAC_W + 1;
  localparam int RW = FRAC_W + 2;
  localparam int QW = FRAC_W + 3;
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [EW-1:0] BIAS_E = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX_E = EW'(2**EXP_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_ROUND, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [MW-1:0]        dvs_q, dvs_d;
  logic [QW-1:0]        quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 spec_q, spec_d;
  logic [W-1:0]         spec_res_q, spec_res_d;
  logic [4:0]           spec_flg_q, spec_flg_d;
  logic [W-1:0]         data_q, data_d;
  logic [4:0]           flags_q, flags_d;

`ifdef FP_DIV_SUBNORM_EN
  function automatic logic [EW-1:0] lzc(input logic [MW-1:0] m);
    logic [EW-1:0] n;
    n = EW'(MW);
    for (int i = 0; i < MW; i++)
      if (m[i]) n = EW'(MW - 1 - i);
    return n;
  endfunction
`endif

  // ---------------- PREP: unpack, classify, normalise ----------------
  logic [EXP_W-1:0]     ea, eb;
  logic [FRAC_W-1:0]    fa, fb;
  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                 a_lt, p_spec;
  logic [MW-1:0]        nm_a, nm_b;
  logic signed [EW-1:0] xa, xb, p_exp;
  logic [RW-1:0]        p_rem;
  logic [W-1:0]         p_res;
  logic [4:0]           p_flg;
`ifdef FP_DIV_SUBNORM_EN
  logic [EW-1:0]        la, lb;
`endif

  always_comb begin
    ea     = a_q[W-2:FRAC_W];
    eb     = b_q[W-2:FRAC_W];
    fa     = a_q[FRAC_W-1:0];
    fb     = b_q[FRAC_W-1:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_snan = a_nan & ~fa[FRAC_W-1];
    b_snan = b_nan & ~fb[FRAC_W-1];
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
`ifdef FP_DIV_SUBNORM_EN
    a_zero = ~(|ea) & ~(|fa);
    b_zero = ~(|eb) & ~(|fb);
    // subnormals use exponent 1 and are shifted up to 1.f, exponent pays for the shift
    la     = lzc({|ea, fa});
    lb     = lzc({|eb, fb});
    nm_a   = {|ea, fa} << la;
    nm_b   = {|eb, fb} << lb;
    xa     = $signed({2'b00, ea | EXP_W'(~(|ea))}) - $signed(la);
    xb     = $signed({2'b00, eb | EXP_W'(~(|eb))}) - $signed(lb);
`else
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    nm_a   = {1'b1, fa};
    nm_b   = {1'b1, fb};
    xa     = $signed({2'b00, ea});
    xb     = $signed({2'b00, eb});
`endif
    a_lt   = nm_a < nm_b;
    p_rem  = a_lt ? {nm_a, 1'b0} : {1'b0, nm_a};
    p_exp  = xa - xb + BIAS_E - $signed(EW'(a_lt));

    p_spec = 1'b1;
    p_flg  = 5'b00000;
    p_res  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    if (a_nan | b_nan)
      p_flg = {a_snan | b_snan, 4'b0000};
    else if ((a_zero & b_zero) | (a_inf & b_inf))
      p_flg = 5'b10000;
    else if (b_zero) begin
      p_res = {a_q[W-1] ^ b_q[W-1], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      p_flg = 5'b01000;
    end else if (a_zero | b_inf)
      p_res = {a_q[W-1] ^ b_q[W-1], {(W-1){1'b0}}};
    else if (a_inf)
      p_res = {a_q[W-1] ^ b_q[W-1], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else begin
      p_spec = 1'b0;
      p_res  = '0;
    end
  end

  // ---------------- DIV: one restoring step ----------------
  logic          d_ge;
  logic [RW-1:0] d_diff;

  always_comb begin
    d_ge   = rem_q >= {1'b0, dvs_q};
    d_diff = d_ge ? rem_q - {1'b0, dvs_q} : rem_q;
  end

  // ---------------- ROUND: RNE, overflow, underflow ----------------
  logic                 sticky, up_n, inx_n, ovf, tiny;
  logic [MW:0]          mr;
  logic [EXP_W-1:0]     em1;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         r_res;
  logic [4:0]           r_flg;
`ifdef FP_DIV_SUBNORM_EN
  logic [EW-1:0]        sh;
  logic [CW-1:0]        sh_c;
  logic [QW-1:0]        sq;
  logic                 lost, ss, up_s;
  logic [MW-1:0]        ms;
`endif

  always_comb begin
    sticky = |rem_q;
    up_n   = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
    inx_n  = (|quo_q[1:0]) | sticky;
    mr     = {1'b0, quo_q[QW-1:2]} + (MW+1)'(up_n);
    exp_r  = exp_q + $signed(EW'(mr[MW]));
    em1    = exp_q[EXP_W-1:0] - 1'b1;
    ovf    = exp_r >= EMAX_E;
    tiny   = exp_q[EW-1] | (exp_q == '0);
`ifdef FP_DIV_SUBNORM_EN
    sh     = EW'(1) - exp_q;
    sh_c   = (sh > EW'(QW)) ? CW'(QW) : sh[CW-1:0];
    sq     = quo_q >> sh_c;
    lost   = |(quo_q & ~({QW{1'b1}} << sh_c));
    ss     = sq[0] | lost | sticky;
    up_s   = sq[1] & (ss | sq[2]);
    ms     = sq[QW-1:2] + MW'(up_s);
`endif
    r_res  = '0;
    r_flg  = 5'b00000;
    if (spec_q) begin
      r_res = spec_res_q;
      r_flg = spec_flg_q;
    end else if (tiny) begin
`ifdef FP_DIV_SUBNORM_EN
      // a rounding carry into bit FRAC_W lands exactly on the smallest normal encoding
      r_res = {sign_q, EXP_W'(ms[FRAC_W]), ms[FRAC_W-1:0]};
      r_flg = {3'b000, sq[1] | ss, sq[1] | ss};
`else
      r_res = {sign_q, {(W-1){1'b0}}};
      r_flg = 5'b00011;
`endif
    end else if (ovf) begin
      r_res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      r_flg = 5'b00101;
    end else begin
      // hidden bit (or rounding carry) adds into exp-1, yielding exp or exp+1
      r_res = {sign_q, {em1, {FRAC_W{1'b0}}} + (W-1)'(mr)};
      r_flg = {4'b0000, inx_n};
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    data_d     = data_q;
    flags_d    = flags_q;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        a_d     = in_a;
        b_d     = in_b;
        state_d = S_PREP;
      end
      S_PREP: begin
        exp_d      = p_exp;
        sign_d     = a_q[W-1] ^ b_q[W-1];
        rem_d      = p_rem;
        dvs_d      = nm_b;
        quo_d      = '0;
        cnt_d      = '0;
        spec_d     = p_spec;
        spec_res_d = p_res;
        spec_flg_d = p_flg;
        state_d    = S_DIV;
      end
      S_DIV: begin
        rem_d = d_diff << 1;
        quo_d = {quo_q[QW-2:0], d_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QW - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        data_d  = r_res;
        flags_d = r_flg;
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      data_q     <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter at binary64: directed cases, handshake/reset behaviour, random operands
// checked against a model built on native double division plus exact integer checks for the flags.
module tb_fp_div_iter;
  localparam int LAT = 52 + 5;
`ifdef FP_DIV_SUBNORM_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_a, in_b, out_data;
  logic [4:0]  out_flags;
  int          errors = 0;
  int          checks = 0;

  fp_div_iter #(.EXP_W(11), .FRAC_W(52)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sign of (sr*sb*2^(er+eb) - sa*2^ea), all significands non-zero
  function automatic int cmp_prod(input logic [63:0] sr, input int er, input logic [63:0] sb,
                                  input int eb, input logic [63:0] sa, input int ea);
    logic [255:0] l, r;
    int d;
    l = 256'(sr) * 256'(sb);
    r = 256'(sa);
    d = er + eb - ea;
    if (d > 150) return 1;
    if (d < -150) return -1;
    if (d >= 0) l = l << d;
    else        r = r << (-d);
    return (l > r) ? 1 : ((l < r) ? -1 : 0);
  endfunction

  task automatic ref_div(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [4:0] f);
    logic [10:0] ea, eb;
    logic [51:0] fa, fb;
    logic        s, an, bn, as_, bs_, ai, bi, az, bz, tiny, inx;
    logic [63:0] sga, sgb, sgr, q;
    int          xa, xb, xr;
    ea = a[62:52]; fa = a[51:0]; eb = b[62:52]; fb = b[51:0];
    s   = a[63] ^ b[63];
    an  = (ea == 11'h7FF) && (fa != 0);
    bn  = (eb == 11'h7FF) && (fb != 0);
    as_ = an && !fa[51];
    bs_ = bn && !fb[51];
    ai  = (ea == 11'h7FF) && (fa == 0);
    bi  = (eb == 11'h7FF) && (fb == 0);
    az  = (ea == 0) && ((fa == 0) || !SUBN);
    bz  = (eb == 0) && ((fb == 0) || !SUBN);
    if (an || bn) begin r = 64'h7FF8000000000000; f = {as_ | bs_, 4'b0000}; return; end
    if ((az && bz) || (ai && bi)) begin r = 64'h7FF8000000000000; f = 5'b10000; return; end
    if (bz) begin r = {s, 11'h7FF, 52'h0}; f = 5'b01000; return; end
    if (az || bi) begin r = {s, 63'h0}; f = 5'b00000; return; end
    if (ai) begin r = {s, 11'h7FF, 52'h0}; f = 5'b00000; return; end
    sga = (ea == 0) ? {12'h0, fa} : {11'h0, 1'b1, fa};
    sgb = (eb == 0) ? {12'h0, fb} : {11'h0, 1'b1, fb};
    xa  = ((ea == 0) ? 1 : int'(ea)) - 1075;
    xb  = ((eb == 0) ? 1 : int'(eb)) - 1075;
    // exact quotient below the smallest normal 2^-1022
    tiny = cmp_prod(64'd1, -1022, sgb, xb, sga, xa) > 0;
    if (!SUBN && tiny) begin r = {s, 63'h0}; f = 5'b00011; return; end
    q = $realtobits($bitstoreal(a) / $bitstoreal(b));
    if (q[62:52] == 11'h7FF) begin r = q; f = 5'b00101; return; end
    if (q[62:0] == 0) inx = 1'b1;
    else begin
      sgr = (q[62:52] == 0) ? {12'h0, q[51:0]} : {11'h0, 1'b1, q[51:0]};
      xr  = ((q[62:52] == 0) ? 1 : int'(q[62:52])) - 1075;
      inx = cmp_prod(sgr, xr, sgb, xb, sga, xa) != 0;
    end
    r = q;
    f = {3'b000, tiny & inx, inx};
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic [4:0] ef);
    int n;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, "/latency"}, 64'(n), 64'(LAT));
    check({tag, "/data"}, out_data, er);
    check({tag, "/flags"}, 64'(out_flags), 64'(ef));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/drop"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 15))
      0: v[62:0] = '0;
      1: v[62:0] = {11'h7FF, 52'h0};
      2: begin v[62:52] = 11'h7FF; if (v[51:0] == 0) v[0] = 1'b1; end
      3: v[62:52] = 11'h0;
      4: v[62:52] = 11'($urandom_range(1, 60));
      5: v[62:52] = 11'($urandom_range(1990, 2046));
      6, 7: begin v[47:0] = '0; v[62:52] = 11'($urandom_range(1000, 1050)); end
      default: v[62:52] = 11'($urandom_range(900, 1150));
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] ra, rb, er, hd;
    logic [4:0]  ef, hf;
    int n, seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/in_ready", 64'(in_ready), 64'd1);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/out_data", out_data, 64'd0);
    check("rst/out_flags", 64'(out_flags), 64'd0);
    rst = 1'b0;

    do_op("10div2",   64'h4024000000000000, 64'h4000000000000000, 64'h4014000000000000, 5'b00000);
    do_op("1div3",    64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00001);
    do_op("neg4div2", 64'hC010000000000000, 64'h4000000000000000, 64'hC000000000000000, 5'b00000);
    do_op("1div0",    64'h3FF0000000000000, 64'h0,                64'h7FF0000000000000, 5'b01000);
    do_op("0div0",    64'h0,                64'h0,                64'h7FF8000000000000, 5'b10000);
    do_op("snan",     64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b10000);
    do_op("qnan",     64'h3FF0000000000000, 64'hFFF8000000000123, 64'h7FF8000000000000, 5'b00000);
    do_op("infdinf",  64'hFFF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 5'b10000);
    do_op("0divneg",  64'h0,                64'hC000000000000000, 64'h8000000000000000, 5'b00000);
    do_op("xdivinf",  64'h4000000000000000, 64'hFFF0000000000000, 64'h8000000000000000, 5'b00000);
    do_op("infdivx",  64'hFFF0000000000000, 64'hC000000000000000, 64'h7FF0000000000000, 5'b00000);
    do_op("ovf",      64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 5'b00101);
    if (SUBN)
      do_op("tiny", 64'h0010000000000000, 64'h4000000000000000, 64'h0008000000000000, 5'b00000);
    else
      do_op("tiny", 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 5'b00011);

    // result held under back-pressure, new operands ignored while busy
    in_a = 64'h3FF0000000000000; in_b = 64'h4008000000000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("hold/latency", 64'(n), 64'(LAT));
    hd = 64'h3FD5555555555555; hf = 5'b00001;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      @(posedge clk); #1;
      check("hold/data", out_data, hd);
      check("hold/flags", 64'(out_flags), 64'(hf));
      check("hold/in_ready", 64'(in_ready), 64'd0);
      check("hold/out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold/released", 64'(out_valid), 64'd0);

    // reset mid-operation discards it
    in_a = 64'h4024000000000000; in_b = 64'h4000000000000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst/out_valid", 64'(out_valid), 64'd0);
    check("midrst/in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("midrst/no_output", 64'(seen), 64'd0);
    do_op("after_rst", 64'h4024000000000000, 64'h4000000000000000, 64'h4014000000000000, 5'b00000);

    for (int i = 0; i < 200; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      ref_div(ra, rb, er, ef);
      do_op($sformatf("rnd%0d %h/%h", i, ra, rb), ra, rb, er, ef);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
